// File: rtl/axi_regs.sv
`default_nettype none
// ============================================================================
// Module   : axi_regs
// Brief    : AXI4-Lite control/status register responder: ID, scratch,
//            LED control, 32-bit free-running cycle counter (LO/HI snapshot)
//            and committed-write counter.
// Options  : AXI_REGS_STRB_EN - honour w_strb byte lanes on SCRATCH/LEDS;
//            when undefined every write is a full 16-bit write.
// Revision : 1.0 - initial release
// ============================================================================
module axi_regs #(
    parameter logic [15:0] ID_VALUE = 16'hD3B6
) (
    input  logic        a_clk,
    input  logic        a_rst,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  logic [17:0] aw_addr,
    input  logic [2:0]  aw_prot,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [15:0] w_data,
    input  logic [1:0]  w_strb,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [1:0]  b_resp,
    input  logic        ar_valid,
    output logic        ar_ready,
    input  logic [17:0] ar_addr,
    input  logic [2:0]  ar_prot,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [15:0] r_data,
    output logic [1:0]  r_resp,
    output logic [3:0]  leds
);

    localparam logic [1:0]  c_OKAY     = 2'b00;
    localparam logic [1:0]  c_DECERR   = 2'b11;
    localparam logic [17:0] c_NUM_REGS = 18'd6;

    // Registered state and next-state values
    logic        aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, ar_ready_q, ar_ready_d;
    logic        b_valid_q, b_valid_d, r_valid_q, r_valid_d;
    logic [1:0]  b_resp_q, b_resp_d, r_resp_q, r_resp_d;
    logic [15:0] r_data_q, r_data_d;
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [17:0] aw_addr_q, aw_addr_d;
    logic [15:0] w_data_q, w_data_d;
    logic [15:0] scratch_q, scratch_d;
    logic [3:0]  ledreg_q, ledreg_d, leds_q, leds_d;
    logic [31:0] cycle_q, cycle_d;
    logic [15:0] hi_snap_q, hi_snap_d, wcount_q, wcount_d;

    // Handshakes and commit qualification
    logic        w_aw_hs, w_w_hs, w_ar_hs, w_have_aw, w_have_w, w_commit, w_wr_ok;
    logic [17:0] w_wr_addr;
    logic [15:0] w_wr_data, w_scratch_new;
    logic [3:0]  w_leds_new;
    logic        w_unused_ok;

    assign w_aw_hs   = aw_valid & aw_ready_q;
    assign w_w_hs    = w_valid & w_ready_q;
    assign w_ar_hs   = ar_valid & ar_ready_q;
    assign w_have_aw = aw_held_q | w_aw_hs;
    assign w_have_w  = w_held_q | w_w_hs;
    // A write commits as soon as both halves are present, fresh or held.
    assign w_commit  = w_have_aw & w_have_w;
    assign w_wr_addr = w_aw_hs ? aw_addr : aw_addr_q;
    assign w_wr_data = w_w_hs ? w_data : w_data_q;
    assign w_wr_ok   = (w_wr_addr < c_NUM_REGS);

`ifdef AXI_REGS_STRB_EN
    logic [1:0] w_strb_q, w_strb_d, w_wr_strb;
    assign w_wr_strb     = w_w_hs ? w_strb : w_strb_q;
    assign w_scratch_new = {w_wr_strb[1] ? w_wr_data[15:8] : scratch_q[15:8],
                            w_wr_strb[0] ? w_wr_data[7:0]  : scratch_q[7:0]};
    assign w_leds_new    = w_wr_strb[0] ? w_wr_data[3:0] : ledreg_q;
    assign w_strb_d      = w_w_hs ? w_strb : w_strb_q;
    assign w_unused_ok   = ^{aw_prot, ar_prot};

    // Strobe hold register, cleared by reset with the other holds
    always_ff @(posedge a_clk) begin
        if (!a_rst) w_strb_q <= 2'b00;
        else        w_strb_q <= w_strb_d;
    end
`else
    assign w_scratch_new = w_wr_data;
    assign w_leds_new    = w_wr_data[3:0];
    assign w_unused_ok   = ^{aw_prot, ar_prot, w_strb};
`endif

    // Next-state for write channel, register file, read channel and counters
    always_comb begin
        aw_held_d = w_commit ? 1'b0 : w_have_aw;
        w_held_d  = w_commit ? 1'b0 : w_have_w;
        aw_addr_d = w_aw_hs ? aw_addr : aw_addr_q;
        w_data_d  = w_w_hs ? w_data : w_data_q;
        b_valid_d = w_commit | (b_valid_q & ~b_ready);
        b_resp_d  = b_resp_q;
        scratch_d = scratch_q;
        ledreg_d  = ledreg_q;
        wcount_d  = wcount_q;
        if (w_commit) begin
            b_resp_d = w_wr_ok ? c_OKAY : c_DECERR;
            if (w_wr_ok) wcount_d = wcount_q + 16'd1;
            if (w_wr_addr == 18'd1) scratch_d = w_scratch_new;
            if (w_wr_addr == 18'd2) ledreg_d  = w_leds_new;
        end

        r_valid_d = w_ar_hs | (r_valid_q & ~r_ready);
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        hi_snap_d = hi_snap_q;
        if (w_ar_hs) begin
            r_resp_d = c_OKAY;
            case (ar_addr)
                18'd0: r_data_d = ID_VALUE;
                18'd1: r_data_d = scratch_q;
                18'd2: r_data_d = {12'h000, ledreg_q};
                18'd3: begin
                    r_data_d  = cycle_q[15:0];
                    hi_snap_d = cycle_q[31:16];
                end
                18'd4: r_data_d = hi_snap_q;
                18'd5: r_data_d = wcount_q;
                default: begin
                    r_data_d = 16'h0000;
                    r_resp_d = c_DECERR;
                end
            endcase
        end

        // Readies are registered copies of their next-cycle conditions.
        aw_ready_d = ~aw_held_d & ~b_valid_d;
        w_ready_d  = ~w_held_d & ~b_valid_d;
        ar_ready_d = ~r_valid_d;
        cycle_d    = cycle_q + 32'd1;
        leds_d     = ledreg_q;
    end

    // State register with synchronous active-low reset
    always_ff @(posedge a_clk) begin
        if (!a_rst) begin
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            ar_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            r_valid_q  <= 1'b0;
            b_resp_q   <= 2'b00;
            r_resp_q   <= 2'b00;
            r_data_q   <= 16'h0000;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_addr_q  <= 18'd0;
            w_data_q   <= 16'h0000;
            scratch_q  <= 16'h0000;
            ledreg_q   <= 4'h0;
            leds_q     <= 4'h0;
            cycle_q    <= 32'd0;
            hi_snap_q  <= 16'h0000;
            wcount_q   <= 16'h0000;
        end else begin
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            ar_ready_q <= ar_ready_d;
            b_valid_q  <= b_valid_d;
            r_valid_q  <= r_valid_d;
            b_resp_q   <= b_resp_d;
            r_resp_q   <= r_resp_d;
            r_data_q   <= r_data_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            scratch_q  <= scratch_d;
            ledreg_q   <= ledreg_d;
            leds_q     <= leds_d;
            cycle_q    <= cycle_d;
            hi_snap_q  <= hi_snap_d;
            wcount_q   <= wcount_d;
        end
    end

    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q;
    assign ar_ready = ar_ready_q;
    assign b_valid  = b_valid_q;
    assign b_resp   = b_resp_q;
    assign r_valid  = r_valid_q;
    assign r_data   = r_data_q;
    assign r_resp   = r_resp_q;
    assign leds     = leds_q;

endmodule
`default_nettype wire

// File: doc/axi_regs.md
# axi_regs

AXI4-Lite responder holding a small control/status register file: ID, scratch, LED control, a free-running cycle counter and a write counter. It is the slave end of the `uart_debug` AXI master and is instantiated in place of, or decoded beside, the memory slave. The host can use it to check the bus path and drive LEDs before touching RAM.

## Interface
- `ID_VALUE`, 16'hD3B6: constant returned at register 0.
- `a_clk`  in  1  clock; all logic on its rising edge.
- `a_rst`  in  1  reset, synchronous, active-low.
- `aw_valid`/`aw_ready`  in/out  1  write-address handshake.
- `aw_addr`  in  18  word address.
- `aw_prot`  in  3  ignored.
- `w_valid`/`w_ready`  in/out  1  write-data handshake.
- `w_data`  in  16  write data.
- `w_strb`  in  2  byte strobes; see Configuration.
- `b_valid`/`b_ready`  out/in  1  write-response handshake.
- `b_resp`  out  2  write response.
- `ar_valid`/`ar_ready`  in/out  1  read-address handshake.
- `ar_addr`  in  18  word address.
- `ar_prot`  in  3  ignored.
- `r_valid`/`r_ready`  out/in  1  read-data handshake.
- `r_data`  out  16  read data.
- `r_resp`  out  2  read response.
- `leds`  out  4  LEDS register bits [3:0].

## Operation
- Register map (word address):
  - 0 ID: RO, value `ID_VALUE`.
  - 1 SCRATCH: RW, 16 bits.
  - 2 LEDS: RW, bits [3:0]; bits [15:4] read 0.
  - 3 CYCLE_LO: RO. A read returns `cycle[15:0]` and snapshots `cycle[31:16]` into HI_SNAP.
  - 4 CYCLE_HI: RO, returns HI_SNAP.
  - 5 WCOUNT: RO. Counts committed writes to addresses 0–5; wraps at 16'hFFFF→0.
- Addresses 6–0x3FFFF:
  - Response is 2'b11 (DECERR).
  - Reads return 16'h0000.
  - Writes have no effect and do not count.
- Valid addresses respond 2'b00 (OKAY). A write to an RO register responds OKAY, is ignored, but counts in WCOUNT.
- `cycle` is 32 bits, increments every cycle and wraps at 2^32.
- Write channel:
  - AW and W are accepted independently into one-entry holds.
  - `aw_ready` = !aw_held & !b_valid; `w_ready` = !w_held & !b_valid.
  - The write commits on the edge where both address and data become available, whether just handshaked or previously held. `b_valid` rises at that same edge.
  - `b_valid` and `b_resp` are held until `b_ready`. The holds clear on commit.
- Read channel:
  - `ar_ready` = !r_valid.
  - On an AR handshake, `r_data`/`r_resp` are registered and `r_valid` rises at that edge.
  - `r_data`/`r_resp`/`r_valid` stay stable until `r_ready`.
- Read and write channels are fully independent and may complete in the same cycle.

## Timing
- Reset (`a_rst`=0 at an edge):
  - `aw_ready`, `w_ready`, `ar_ready`, `b_valid`, `r_valid` = 0.
  - `b_resp`, `r_resp`, `r_data` = 0; `leds` = 0.
  - SCRATCH, LEDS, `cycle`, HI_SNAP, WCOUNT and the holds = 0.
  - The readies are registered, so they assert on the first cycle after reset is released.
- Reset mid-transaction drops held AW/W and any pending B/R without response.
- Write latency: if AW and W handshake in cycle N, `b_valid` = 1 in cycle N+1 and the register shows the new value in cycle N+1. Max throughput is one write per 2 cycles.
- AW in cycle N, W in cycle N+k: commit and `b_valid` in cycle N+k+1.
- Read latency: AR handshake in cycle N gives `r_valid` in N+1. Max throughput is one read per 2 cycles when `r_ready` is held high.
- Same-cycle read and write commit to the same register: the read returns the pre-write value.
- CYCLE_LO value is `cycle` sampled at the AR handshake edge.
- `leds` updates in the cycle after the commit edge.

## Configuration
- `AXI_REGS_STRB_EN` defined:
  - `w_strb[0]` gates byte [7:0] and `w_strb[1]` gates byte [15:8] of SCRATCH/LEDS.
  - strb=2'b00 commits nothing but still responds OKAY and increments WCOUNT.
- Undefined: `w_strb` is ignored and every write is a full 16-bit write. This is the mode used with the debug master, which ties strobes to 0.

## Test plan
- Reset, then read addr 0 → `r_data`=16'hD3B6, `r_resp`=0 one cycle after AR.
- Write SCRATCH=16'hA55A with AW and W together, `b_ready`=1 → `b_valid` next cycle with OKAY; read back 16'hA55A; WCOUNT=1.
- AW for addr 2 in cycle 0, W=16'h000F in cycle 5 → `b_valid` in cycle 6, `leds`=4'hF from cycle 7; `aw_ready`=0 in cycles 1–6.
- Read/write addr 0x100 → `r_data`=0, `r_resp`=2'b11, `b_resp`=2'b11; WCOUNT unchanged.
- Hold `r_ready`=0 for 4 cycles after a read → `r_valid`/`r_data` stable and `ar_ready`=0 throughout. Read CYCLE_LO then CYCLE_HI → the concatenation is consistent and nonzero.
- `AXI_REGS_STRB_EN` with SCRATCH=16'h1234, write 16'hABCD with strb=2'b01 → SCRATCH reads 16'h12CD. Without the macro → reads 16'hABCD.
